star_game_sched: RTL and testbench

- Scoring and level scheduler that feeds starColors: owns pts1, pts2 and level_state.
- Arbitrates score events from two players and sequences PLAY -> CELEBRATE -> next level or GAME_OVER.
- Times the celebration hold in video frames using finish_frame.
- Sits between the ball/paddle collision logic (score pulses) and the star/colour renderer.

---
 rtl/star_game_sched_pkg.sv | 25 ++
 rtl/star_game_sched_if.sv | 31 +++
 rtl/star_game_sched_arb.sv | 53 +++++
 rtl/star_game_sched.sv | 139 +++++++++++++
 tb/tb_star_game_sched.sv | 185 ++++++++++++++++++
 5 files changed

// File: rtl/star_game_sched_pkg.sv
// Shared types for the star game scheduler.
// Contents: game state encoding, level and winner types, arbiter priority
// encoding, and the round_winner codes.
package star_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PLAY      = 2'd1,
    CELEBRATE = 2'd2,
    GAME_OVER = 2'd3
  } game_state_t;

  typedef logic [1:0] level_t;
  typedef logic [1:0] winner_t;

  typedef enum logic {
    PRIO_P1 = 1'b0,
    PRIO_P2 = 1'b1
  } prio_t;

  localparam winner_t WINNER_NONE = 2'b00;
  localparam winner_t WINNER_P1   = 2'b01;
  localparam winner_t WINNER_P2   = 2'b10;

endpackage

// File: rtl/star_game_sched_if.sv
// Bundle between the scheduler and its neighbours.
// Inputs to the scheduler: start, finish_frame, score1, score2 (pulses).
// Outputs from the scheduler: pts1, pts2, level_state, round_winner,
// play_en, game_over.
// master: the side driving pulses and observing scores (collision logic,
// renderer, bench). slave: the scheduler.
interface star_game_sched_if;
  import star_pkg::*;

  logic       start;
  logic       finish_frame;
  logic       score1;
  logic       score2;
  logic [3:0] pts1;
  logic [3:0] pts2;
  level_t     level_state;
  winner_t    round_winner;
  logic       play_en;
  logic       game_over;

  modport master (
    output start, finish_frame, score1, score2,
    input  pts1, pts2, level_state, round_winner, play_en, game_over
  );

  modport slave (
    input  start, finish_frame, score1, score2,
    output pts1, pts2, level_state, round_winner, play_en, game_over
  );

endinterface

// File: rtl/star_game_sched_arb.sv
// Round-robin arbiter for the two score inputs.
// Ports: clock, reset (sync, active-low), en (grants allowed), clear
// (drop pending points, priority back to player 1), score1/score2 (pulses),
// grant1/grant2 (one-hot or zero, combinational).
// A request that loses is remembered in its pend flag; a new pulse while
// the flag is already set merges into the same single point.
module score_rr_arb
  import star_pkg::*;
(
  input  logic clock,
  input  logic reset,
  input  logic en,
  input  logic clear,
  input  logic score1,
  input  logic score2,
  output logic grant1,
  output logic grant2
);

  logic  pend1;
  logic  pend2;
  prio_t prio;
  logic  req1;
  logic  req2;

  always_comb begin
    req1   = score1 | pend1;
    req2   = score2 | pend2;
    grant1 = en && req1 && (!req2 || (prio == PRIO_P1));
    grant2 = en && req2 && (!req1 || (prio == PRIO_P2));
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      pend1 <= 1'b0;
      pend2 <= 1'b0;
      prio  <= PRIO_P1;
    end else if (clear) begin
      pend1 <= 1'b0;
      pend2 <= 1'b0;
      prio  <= PRIO_P1;
    end else if (grant1) begin
      pend1 <= 1'b0;
      pend2 <= req2;
      prio  <= PRIO_P2;
    end else if (grant2) begin
      pend2 <= 1'b0;
      pend1 <= req1;
      prio  <= PRIO_P1;
    end
  end

endmodule

// File: rtl/star_game_sched.sv
// Scoring and level scheduler feeding the star/colour renderer.
// Ports: clock, reset (sync, active-low), bus (slave side of
// star_game_sched_if: start/finish_frame/score pulses in; pts1, pts2,
// level_state, round_winner, play_en, game_over out).
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | after reset, waiting for start
// PLAY      | ball live, score pulses arbitrated into pts1/pts2
// CELEBRATE | round won, holding CELEB_FRAMES video frames
// GAME_OVER | last level won, outputs frozen until start
module star_game_sched
  import star_pkg::*;
#(
  parameter int WIN_PTS      = 9,
  parameter int CELEB_FRAMES = 120,
  parameter int NUM_LEVELS   = 4
) (
  input logic              clock,
  input logic              reset,
  star_game_sched_if.slave bus
);

  localparam int         FCW        = $clog2(CELEB_FRAMES + 1);
  localparam logic [3:0] WIN_M1     = 4'(WIN_PTS - 1);
  localparam logic [FCW-1:0] FRAME_LAST = FCW'(CELEB_FRAMES - 1);
  localparam level_t     LEVEL_LAST = level_t'(NUM_LEVELS - 1);

  game_state_t    state;
  game_state_t    state_nxt;
  logic [3:0]     pts1;
  logic [3:0]     pts2;
  level_t         level;
  winner_t        winner;
  logic [FCW-1:0] frame_cnt;

  logic grant1;
  logic grant2;
  logic win1;
  logic win2;
  logic frame_last;
  logic start_ok;
  logic arb_clear;

  score_rr_arb u_arb (
    .clock  (clock),
    .reset  (reset),
    .en     (state == PLAY),
    .clear  (arb_clear),
    .score1 (bus.score1),
    .score2 (bus.score2),
    .grant1 (grant1),
    .grant2 (grant2)
  );

  always_ff @(posedge clock) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    win1       = grant1 && (pts1 == WIN_M1);
    win2       = grant2 && (pts2 == WIN_M1);
    frame_last = bus.finish_frame && (frame_cnt == FRAME_LAST);
    start_ok   = bus.start && ((state == IDLE) || (state == GAME_OVER));
    arb_clear  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) state_nxt = PLAY;
      end
      PLAY: begin
        if (win1 || win2) begin
          state_nxt = CELEBRATE;
          arb_clear = 1'b1;
        end
      end
      CELEBRATE: begin
        if (frame_last) begin
          state_nxt = (level == LEVEL_LAST) ? GAME_OVER : PLAY;
          arb_clear = 1'b1;
        end
      end
      GAME_OVER: begin
        if (bus.start) state_nxt = PLAY;
      end
      default: state_nxt = IDLE;
    endcase
    // Fresh game always starts with player 1 favoured and nothing pending.
    if (start_ok) arb_clear = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      pts1      <= 4'd0;
      pts2      <= 4'd0;
      level     <= '0;
      winner    <= WINNER_NONE;
      frame_cnt <= '0;
    end else begin
      case (state)
        IDLE, GAME_OVER: begin
          if (bus.start) begin
            pts1   <= 4'd0;
            pts2   <= 4'd0;
            level  <= '0;
            winner <= WINNER_NONE;
          end
        end
        PLAY: begin
          if (grant1) pts1 <= pts1 + 4'd1;
          if (grant2) pts2 <= pts2 + 4'd1;
          if (win1) winner <= WINNER_P1;
          if (win2) winner <= WINNER_P2;
          frame_cnt <= '0;
        end
        CELEBRATE: begin
          if (bus.finish_frame) frame_cnt <= frame_cnt + 1'b1;
          // Last level keeps pts/winner on display through GAME_OVER.
          if (frame_last && (level != LEVEL_LAST)) begin
            level  <= level + 2'd1;
            pts1   <= 4'd0;
            pts2   <= 4'd0;
            winner <= WINNER_NONE;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.pts1         = pts1;
  assign bus.pts2         = pts2;
  assign bus.level_state  = level;
  assign bus.round_winner = winner;
  assign bus.play_en      = (state == PLAY);
  assign bus.game_over    = (state == GAME_OVER);

endmodule

// File: tb/tb_star_game_sched.sv
module tb_star_game_sched;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   vec_cnt = 0;
  int   err_cnt = 0;

  star_game_sched_if bus ();

  star_game_sched #(
    .WIN_PTS      (9),
    .CELEB_FRAMES (120),
    .NUM_LEVELS   (4)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input int obs, input int exp);
    vec_cnt++;
    if (obs != exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock: inputs held across the posedge, results sampled at negedge.
  task automatic cyc(input logic st, input logic s1, input logic s2, input logic ff);
    bus.start        = st;
    bus.score1       = s1;
    bus.score2       = s2;
    bus.finish_frame = ff;
    @(posedge clock);
    #1;
    bus.start        = 1'b0;
    bus.score1       = 1'b0;
    bus.score2       = 1'b0;
    bus.finish_frame = 1'b0;
    @(negedge clock);
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      cyc(0, 0, 0, 1);
      if (i % 16 == 3) cyc(0, 0, 0, 0);
    end
  endtask

  task automatic win_p1();
    for (int i = 0; i < 9; i++) cyc(0, 1, 0, 0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_pts1"}, bus.pts1, 0);
    chk({tag, "_pts2"}, bus.pts2, 0);
    chk({tag, "_level"}, bus.level_state, 0);
    chk({tag, "_winner"}, bus.round_winner, 0);
    chk({tag, "_play_en"}, bus.play_en, 0);
    chk({tag, "_game_over"}, bus.game_over, 0);
  endtask

  initial begin
    bus.start = 0; bus.score1 = 0; bus.score2 = 0; bus.finish_frame = 0;
    reset = 1'b0;
    @(negedge clock);
    cyc(0, 0, 0, 0);
    cyc(1, 1, 1, 1);
    chk_all_zero("reset");
    reset = 1'b1;
    cyc(0, 0, 0, 0);
    chk("idle_play_en", bus.play_en, 0);

    cyc(1, 0, 0, 0);
    chk("start_play_en", bus.play_en, 1);
    chk("start_pts1", bus.pts1, 0);
    chk("start_level", bus.level_state, 0);

    // Simultaneous scores: player 1 first, player 2 next cycle.
    cyc(0, 1, 1, 0);
    chk("sim_pts1", bus.pts1, 1);
    chk("sim_pts2_a", bus.pts2, 0);
    cyc(0, 0, 0, 0);
    chk("sim_pts2_b", bus.pts2, 1);
    // Priority back to player 1.
    cyc(0, 1, 1, 0);
    chk("prio_pts1", bus.pts1, 2);
    chk("prio_pts2", bus.pts2, 1);
    // pend2 set; second score2 pulse merges.
    cyc(0, 0, 1, 0);
    chk("merge_pts2_a", bus.pts2, 2);
    cyc(0, 0, 0, 0);
    chk("merge_pts2_b", bus.pts2, 2);
    chk("merge_pts1", bus.pts1, 2);
    // Lone request wins regardless of priority.
    cyc(0, 0, 1, 0);
    chk("lone_pts2", bus.pts2, 3);
    cyc(0, 1, 1, 0);
    chk("rr_pts1_a", bus.pts1, 3);
    cyc(0, 1, 0, 0);
    chk("rr_pts2", bus.pts2, 4);
    chk("rr_pts1_b", bus.pts1, 3);
    cyc(0, 0, 0, 0);
    chk("rr_pts1_c", bus.pts1, 4);
    // pts1=4 pts2=4, prio=P2
    for (int i = 0; i < 4; i++) cyc(0, 1, 0, 0);
    chk("pre_win_pts1", bus.pts1, 8);
    chk("pre_win_winner", bus.round_winner, 0);
    chk("pre_win_play", bus.play_en, 1);
    cyc(0, 0, 1, 0);
    chk("pre_win_pts2", bus.pts2, 5);
    // prio=P1: player 1 wins the round, player 2's loser point is dropped.
    cyc(0, 1, 1, 0);
    chk("win_pts1", bus.pts1, 9);
    chk("win_pts2", bus.pts2, 5);
    chk("win_winner", bus.round_winner, 1);
    chk("win_play_en", bus.play_en, 0);
    cyc(0, 0, 1, 0);
    cyc(1, 0, 1, 0);
    chk("celeb_pts2", bus.pts2, 5);
    chk("celeb_play_en", bus.play_en, 0);
    frames(119);
    chk("celeb119_level", bus.level_state, 0);
    chk("celeb119_winner", bus.round_winner, 1);
    chk("celeb119_play_en", bus.play_en, 0);
    cyc(0, 0, 0, 1);
    chk("lvl1_level", bus.level_state, 1);
    chk("lvl1_pts1", bus.pts1, 0);
    chk("lvl1_pts2", bus.pts2, 0);
    chk("lvl1_winner", bus.round_winner, 0);
    chk("lvl1_play_en", bus.play_en, 1);
    cyc(0, 0, 0, 0);
    chk("lvl1_no_pend", bus.pts2, 0);

    win_p1();
    frames(120);
    chk("lvl2_level", bus.level_state, 2);
    win_p1();
    frames(120);
    chk("lvl3_level", bus.level_state, 3);
    chk("lvl3_play_en", bus.play_en, 1);

    for (int i = 0; i < 9; i++) cyc(0, 0, 1, 0);
    chk("lvl3_winner", bus.round_winner, 2);
    frames(119);
    chk("lvl3_not_over", bus.game_over, 0);
    cyc(0, 0, 0, 1);
    chk("go_game_over", bus.game_over, 1);
    chk("go_play_en", bus.play_en, 0);
    chk("go_pts2", bus.pts2, 9);
    chk("go_winner", bus.round_winner, 2);
    chk("go_level", bus.level_state, 3);
    cyc(0, 1, 0, 1);
    chk("go_pts1_held", bus.pts1, 0);
    chk("go_still_over", bus.game_over, 1);
    cyc(1, 0, 0, 0);
    chk("restart_level", bus.level_state, 0);
    chk("restart_play", bus.play_en, 1);
    chk("restart_go", bus.game_over, 0);
    chk("restart_pts2", bus.pts2, 0);
    chk("restart_winner", bus.round_winner, 0);

    win_p1();
    frames(120);
    chk("r_lvl1_level", bus.level_state, 1);
    win_p1();
    frames(50);
    chk("r_celeb_winner", bus.round_winner, 1);
    reset = 1'b0;
    cyc(0, 0, 0, 1);
    chk_all_zero("midreset");
    reset = 1'b1;
    cyc(0, 1, 0, 1);
    chk("post_reset_idle_pts1", bus.pts1, 0);
    cyc(1, 0, 0, 0);
    chk("post_reset_play", bus.play_en, 1);
    chk("post_reset_level", bus.level_state, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
